// File: rtl/pulse_stretch.sv
// Stretches a trigger rising edge into a level pulse of programmable width, with optional dead time.
// Define PULSE_STRETCH_RETRIG_EN to let an edge during the pulse restart it with the new width.
module pulse_stretch #(
    parameter int CNT_W   = 16,
    parameter int HOLDOFF = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_trig,
    input  logic [CNT_W-1:0] inp_width,
    input  logic             inp_clr_drop,
    output logic             out_pulse,
    output logic             out_busy,
    output logic             out_drop
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);

    state_t           state, next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] width_eff;
    logic             trig_prev, trig_edge, ignored;
    logic             pulse_next, busy_next, drop_next;

    assign trig_edge = inp_trig & ~trig_prev;
    // A zero width still yields a one-clock pulse.
    assign width_eff = (inp_width == '0) ? ONE : inp_width;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            trig_prev <= 1'b0;
            out_pulse <= 1'b0;
            out_busy  <= 1'b0;
            out_drop  <= 1'b0;
        end else begin
            state     <= next;
            cnt       <= cnt_next;
            trig_prev <= inp_trig;
            out_pulse <= pulse_next;
            out_busy  <= busy_next;
            out_drop  <= drop_next;
        end
    end

    always_comb begin
        next     = state;
        cnt_next = cnt;
        ignored  = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    next     = ACTIVE;
                    cnt_next = width_eff;
                end
            end
            ACTIVE: begin
                if (cnt == ONE) begin
                    if (HOLDOFF > 0) begin
                        next     = HOLD;
                        cnt_next = HOLD_LOAD;
                    end else begin
                        next     = IDLE;
                        cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt - ONE;
                end
                // An edge on the final active clock still belongs to this pulse.
                if (trig_edge) begin
`ifdef PULSE_STRETCH_RETRIG_EN
                    next     = ACTIVE;
                    cnt_next = width_eff;
`else
                    ignored  = 1'b1;
`endif
                end
            end
            HOLD: begin
                if (cnt == ONE) begin
                    next     = IDLE;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt - ONE;
                end
                if (trig_edge) ignored = 1'b1;
            end
            default: begin
                next     = IDLE;
                cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        pulse_next = (next == ACTIVE);
        busy_next  = (next != IDLE);
        drop_next  = ignored | (out_drop & ~inp_clr_drop);
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: one instance without dead time, one with HOLDOFF=4.
// Expected pulse/busy lengths are queued at stimulus time and checked as each level falls.
module tb_pulse_stretch;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trig0 = 1'b0, clr0 = 1'b0;
    logic [CNT_W-1:0] width0 = '0;
    logic             pulse0, busy0, drop0;
    logic             trig4 = 1'b0, clr4 = 1'b0;
    logic [CNT_W-1:0] width4 = '0;
    logic             pulse4, busy4, drop4;

    int total = 0;
    int bad   = 0;
    int q0 [$];
    int q1 [$];
    int q2 [$];
    int q3 [$];
    int len [4];
    string names [4] = '{"pulse0", "busy0", "pulse4", "busy4"};

    always #5 clk = ~clk;

    pulse_stretch #(.CNT_W(CNT_W), .HOLDOFF(0)) u0 (
        .clk(clk), .rst(rst), .inp_trig(trig0), .inp_width(width0),
        .inp_clr_drop(clr0), .out_pulse(pulse0), .out_busy(busy0), .out_drop(drop0));

    pulse_stretch #(.CNT_W(CNT_W), .HOLDOFF(4)) u4 (
        .clk(clk), .rst(rst), .inp_trig(trig4), .inp_width(width4),
        .inp_clr_drop(clr4), .out_pulse(pulse4), .out_busy(busy4), .out_drop(drop4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int pop_exp(input int i, output bit ok);
        ok = 1'b1;
        case (i)
            0: if (q0.size() != 0) return q0.pop_front();
            1: if (q1.size() != 0) return q1.pop_front();
            2: if (q2.size() != 0) return q2.pop_front();
            default: if (q3.size() != 0) return q3.pop_front();
        endcase
        ok = 1'b0;
        return 0;
    endfunction

    // Monitor: measures each high level and compares its length on the falling sample.
    initial for (int i = 0; i < 4; i++) len[i] = 0;
    always @(negedge clk) begin
        logic [3:0] s;
        int         e;
        bit         ok;
        s = {busy4, pulse4, busy0, pulse0};
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                len[i]++;
            end else if (len[i] != 0) begin
                e = pop_exp(i, ok);
                if (!ok) begin
                    total++;
                    bad++;
                    $display("FAIL %s unexpected level length=%0d", names[i], len[i]);
                end else begin
                    chk({names[i], "_len"}, len[i], e);
                end
                len[i] = 0;
            end
        end
    end

    task automatic fire0(input int w);
        trig0 = 1'b1;
        width0 = CNT_W'(w);
        tick();
        trig0 = 1'b0;
    endtask

    task automatic fire4(input int w);
        trig4 = 1'b1;
        width4 = CNT_W'(w);
        tick();
        trig4 = 1'b0;
    endtask

    task automatic exp0(input int n);
        q0.push_back(n);
        q1.push_back(n);
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (busy0 && n < 1000) begin
            tick();
            n++;
        end
        chk("idle0_timeout", int'(busy0), 0);
        tick();
        tick();
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 1000) begin
            tick();
            n++;
        end
        chk("idle4_timeout", int'(busy4), 0);
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pulse0", int'(pulse0), 0);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_drop0", int'(drop0), 0);
        chk("rst_busy4", int'(busy4), 0);
        rst = 1'b0;
        tick();

        // width 5, no dead time
        exp0(5);
        fire0(5);
        chk("t1_pulse_first", int'(pulse0), 1);
        wait_idle0();

        // width 0 behaves as 1, and full-scale width
        exp0(1);
        fire0(0);
        wait_idle0();
        exp0(255);
        fire0(255);
        wait_idle0();

        // held-high trigger is a single edge
        exp0(3);
        trig0 = 1'b1;
        width0 = 8'd3;
        repeat (20) tick();
        trig0 = 1'b0;
        wait_idle0();
        chk("t3_drop", int'(drop0), 0);

        // edge two clocks into a 4-clock pulse
        trig0 = 1'b1; width0 = 8'd4; tick();
        trig0 = 1'b0; tick();
        trig0 = 1'b1; width0 = 8'd6; tick();
        trig0 = 1'b0;
`ifdef PULSE_STRETCH_RETRIG_EN
        exp0(8);
        wait_idle0();
        chk("t5_drop", int'(drop0), 0);
`else
        exp0(4);
        wait_idle0();
        chk("t5_drop", int'(drop0), 1);
`endif
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        chk("t5_clr", int'(drop0), 0);

        // reset on the 3rd clock of a 10-clock pulse
        exp0(3);
        fire0(10);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_pulse", int'(pulse0), 0);
        chk("t6_rst_busy", int'(busy0), 0);
        chk("t6_rst_drop", int'(drop0), 0);
        rst = 1'b0;
        tick();
        exp0(10);
        fire0(10);
        wait_idle0();

        // dead time: pulse 2 then busy 4 more clocks
        q2.push_back(2);
        q3.push_back(6);
        fire4(2);
        tick(); tick(); tick();
        trig4 = 1'b1; tick(); trig4 = 1'b0;
        chk("t4_hold_drop", int'(drop4), 1);
        clr4 = 1'b1; tick(); clr4 = 1'b0;
        chk("t4_clr", int'(drop4), 0);
        wait_idle4();
        chk("t4_drop_kept_clear", int'(drop4), 0);
        q2.push_back(2);
        q3.push_back(6);
        fire4(2);
        tick(); tick();
        // ignored edge and clear in the same clock: set wins
        trig4 = 1'b1; clr4 = 1'b1; tick(); trig4 = 1'b0; clr4 = 1'b0;
        chk("t4_set_wins", int'(drop4), 1);
        wait_idle4();

        repeat (4) tick();
        chk("q_pulse0_empty", q0.size(), 0);
        chk("q_busy0_empty", q1.size(), 0);
        chk("q_pulse4_empty", q2.size(), 0);
        chk("q_busy4_empty", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
